// File: rtl/jtpopeye_rom_rq.sv
// ---------------------------------------------------------------------------
// jtpopeye_rom_rq
//
// SDRAM ROM read arbiter sitting between the SDRAM controller and the game
// core. Two clients share one 32-bit SDRAM read port:
//   - main CPU : 15-bit byte address, 8-bit data
//   - OBJ      : 13-bit 32-bit-word address, 32-bit data
// Each client owns a single-line tag cache (one 32-bit line plus tag and
// valid bit). OBJ wins simultaneous misses, but after OBJ_BURST consecutive
// OBJ grants while main is still missing, main is served next.
//
// Ports
//   clk_rom      in   SDRAM clock, all logic on the rising edge
//   rst          in   synchronous reset, active high
//   downloading  in   ROM download in progress: invalidates lines, no grants
//   main_cs      in   main CPU request
//   main_addr    in   [14:0] main CPU byte address
//   main_ok      out  main_data valid for the current main_addr
//   main_data    out  [7:0] selected byte of the main line
//   obj_cs       in   OBJ request
//   obj_addr     in   [12:0] OBJ word address
//   obj_ok       out  obj_data valid for the current obj_addr
//   obj_data     out  [31:0] OBJ line
//   sdram_req    out  read request, held until sdram_ack
//   sdram_addr   out  [21:0] 16-bit-word address, stable while sdram_req=1
//   sdram_ack    in   one-cycle pulse: request accepted
//   data_rdy     in   one-cycle pulse: data_read valid
//   data_read    in   [31:0] read data, low word at the even address
//
// Configuration macro: JTPOPEYE_ROM_CACHE_EN
//   defined   : a line stays valid while its client's cs toggles
//   undefined : a client's valid bit clears whenever its cs is low, so each
//               cs assertion triggers exactly one fetch
// ---------------------------------------------------------------------------
module jtpopeye_rom_rq #(
    parameter logic [21:0] MAIN_OFFSET = 22'h00000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h04000,
    parameter int          OBJ_BURST   = 2
) (
    input  logic        clk_rom,
    input  logic        rst,
    input  logic        downloading,

    input  logic        main_cs,
    input  logic [14:0] main_addr,
    output logic        main_ok,
    output logic [7:0]  main_data,

    input  logic        obj_cs,
    input  logic [12:0] obj_addr,
    output logic        obj_ok,
    output logic [31:0] obj_data,

    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [31:0] data_read
);

    localparam int CNT_W = $clog2(OBJ_BURST + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // per-client line storage
    logic [31:0] r_main_line;
    logic [12:0] r_main_tag;
    logic        r_main_valid;
    logic [31:0] r_obj_line;
    logic [12:0] r_obj_tag;
    logic        r_obj_valid;

    // grant-time snapshot; the fetched line is filed under this tag even if
    // the client has moved on to another address meanwhile
    logic        r_gnt_obj;
    logic [12:0] r_gnt_tag;
    logic [21:0] r_sdram_addr;

    logic [CNT_W-1:0] r_starve_cnt;

    logic        w_main_hit;
    logic        w_obj_hit;
    logic        w_main_miss;
    logic        w_obj_miss;
    logic        w_starved;
    logic        w_main_first;
    logic        w_grant_main;
    logic        w_grant_obj;
    logic        w_line_wr;
    logic [21:0] w_main_sdram_addr;
    logic [21:0] w_obj_sdram_addr;
    logic [7:0]  w_main_bytes [4];

    // ------------------------------------------------------------------
    // Hit detection: purely combinational from registered tag/valid so that
    // ok falls in the same cycle the address leaves the cached line.
    // ------------------------------------------------------------------
    assign w_main_hit  = main_cs & r_main_valid & (r_main_tag == main_addr[14:2]);
    assign w_obj_hit   = obj_cs  & r_obj_valid  & (r_obj_tag  == obj_addr);
    assign w_main_miss = main_cs & ~w_main_hit;
    assign w_obj_miss  = obj_cs  & ~w_obj_hit;

    assign w_starved    = (r_starve_cnt >= CNT_W'(OBJ_BURST));
    assign w_main_first = w_main_miss & (~w_obj_miss | w_starved);

    assign w_main_sdram_addr = MAIN_OFFSET + {8'd0, main_addr[14:2], 1'b0};
    assign w_obj_sdram_addr  = OBJ_OFFSET  + {8'd0, obj_addr, 1'b0};

    // byte lane split of the main line, byte 0 in bits 7:0
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_main_bytes
            assign w_main_bytes[gi] = r_main_line[gi*8 +: 8];
        end
    endgenerate

    assign main_ok    = w_main_hit;
    assign main_data  = w_main_bytes[main_addr[1:0]];
    assign obj_ok     = w_obj_hit;
    assign obj_data   = r_obj_line;
    assign sdram_req  = (r_state == ST_REQ);
    assign sdram_addr = r_sdram_addr;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, grant decision and line write strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant_main = 1'b0;
        w_grant_obj  = 1'b0;
        w_line_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!downloading) begin
                    if (w_main_first) begin
                        w_grant_main = 1'b1;
                        w_state_next = ST_REQ;
                    end else if (w_obj_miss) begin
                        w_grant_obj  = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (downloading) begin
                    // abandon the request; if data arrives with the ack it
                    // is simply dropped
                    w_state_next = ST_IDLE;
                end else if (sdram_ack) begin
                    if (data_rdy) begin
                        // ack and data in the same cycle: complete at once
                        w_line_wr    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // the controller owes us this data even during a download,
                // so wait for it but only store it when not downloading
                if (data_rdy) begin
                    w_line_wr    = ~downloading;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant snapshot and SDRAM address
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_gnt_obj    <= 1'b0;
            r_gnt_tag    <= 13'd0;
            r_sdram_addr <= 22'd0;
        end else if (w_grant_main) begin
            r_gnt_obj    <= 1'b0;
            r_gnt_tag    <= main_addr[14:2];
            r_sdram_addr <= w_main_sdram_addr;
        end else if (w_grant_obj) begin
            r_gnt_obj    <= 1'b1;
            r_gnt_tag    <= obj_addr;
            r_sdram_addr <= w_obj_sdram_addr;
        end
    end

    // ------------------------------------------------------------------
    // Main line
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_main_line  <= 32'd0;
            r_main_tag   <= 13'd0;
            r_main_valid <= 1'b0;
        end else begin
            if (w_line_wr && !r_gnt_obj) begin
                r_main_line  <= data_read;
                r_main_tag   <= r_gnt_tag;
                r_main_valid <= 1'b1;
            end
`ifndef JTPOPEYE_ROM_CACHE_EN
            // without caching, dropping cs forgets the line
            if (!main_cs) begin
                r_main_valid <= 1'b0;
            end
`endif
            if (downloading) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // OBJ line
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_obj_line  <= 32'd0;
            r_obj_tag   <= 13'd0;
            r_obj_valid <= 1'b0;
        end else begin
            if (w_line_wr && r_gnt_obj) begin
                r_obj_line  <= data_read;
                r_obj_tag   <= r_gnt_tag;
                r_obj_valid <= 1'b1;
            end
`ifndef JTPOPEYE_ROM_CACHE_EN
            if (!obj_cs) begin
                r_obj_valid <= 1'b0;
            end
`endif
            if (downloading) begin
                r_obj_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Anti-starvation counter: counts OBJ grants made while main waits.
    // Once it reaches OBJ_BURST the next arbitration goes to main.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_main || !w_main_miss) begin
            r_starve_cnt <= '0;
        end else if (w_grant_obj && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_jtpopeye_rom_rq.sv
// ---------------------------------------------------------------------------
// tb_jtpopeye_rom_rq
//
// Cycle-by-cycle vector table for jtpopeye_rom_rq: each record holds the
// inputs for one clock cycle and the outputs expected in that cycle (after
// the inputs settle, before the next rising edge). A hand-written sequence
// at the end checks miss-to-ok latency with stretched ack/data delays.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtpopeye_rom_rq;

    logic        clk_rom = 1'b0;
    logic        rst;
    logic        downloading;
    logic        main_cs;
    logic [14:0] main_addr;
    logic        main_ok;
    logic [7:0]  main_data;
    logic        obj_cs;
    logic [12:0] obj_addr;
    logic        obj_ok;
    logic [31:0] obj_data;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    int checks   = 0;
    int failures = 0;

    always #5 clk_rom = ~clk_rom;

    jtpopeye_rom_rq dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .main_cs     (main_cs),
        .main_addr   (main_addr),
        .main_ok     (main_ok),
        .main_data   (main_data),
        .obj_cs      (obj_cs),
        .obj_addr    (obj_addr),
        .obj_ok      (obj_ok),
        .obj_data    (obj_data),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    typedef struct {
        logic        rst;
        logic        dl;
        logic        mcs;
        logic [14:0] maddr;
        logic        ocs;
        logic [12:0] oaddr;
        logic        ack;
        logic        rdy;
        logic [31:0] rd;
        logic        e_mok;
        logic [7:0]  e_mdat;
        logic        e_ook;
        logic [31:0] e_odat;
        logic        e_req;
        logic [21:0] e_addr;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(
        input logic r, input logic dl, input logic mcs, input logic [14:0] ma,
        input logic ocs, input logic [12:0] oa, input logic ack, input logic rdy,
        input logic [31:0] rd, input logic mok, input logic [7:0] mdat,
        input logic ook, input logic [31:0] odat, input logic req,
        input logic [21:0] addr);
        vec_t v;
        v.rst = r; v.dl = dl; v.mcs = mcs; v.maddr = ma; v.ocs = ocs;
        v.oaddr = oa; v.ack = ack; v.rdy = rdy; v.rd = rd;
        v.e_mok = mok; v.e_mdat = mdat; v.e_ook = ook; v.e_odat = odat;
        v.e_req = req; v.e_addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        downloading = v.dl;
        main_cs     = v.mcs;
        main_addr   = v.maddr;
        obj_cs      = v.ocs;
        obj_addr    = v.oaddr;
        sdram_ack   = v.ack;
        data_rdy    = v.rdy;
        data_read   = v.rd;
    endtask

    // hard time limit so the bench never hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic cache_mok;
        logic nc_req;
`ifdef JTPOPEYE_ROM_CACHE_EN
        cache_mok = 1'b1;
        nc_req    = 1'b0;
`else
        cache_mok = 1'b0;
        nc_req    = 1'b1;
`endif
        //             rst dl mcs maddr    ocs oaddr   ack rdy rd            mok mdat   ook odat          req addr
        // reset state
        tab.push_back(mk(1,0, 0,15'h000, 0,13'h00, 0,0,32'h0,        0,8'h00, 0,32'h0,        0,22'h0));
        // main miss on 0x0005 -> sdram 0x2, byte 1 = BB
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        0,8'h00, 0,32'h0,        0,22'h0));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        0,8'h00, 0,32'h0,        1,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 1,0,32'h0,        0,8'h00, 0,32'h0,        1,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        0,8'h00, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,1,32'hDDCCBBAA, 0,8'h00, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        1,8'hBB, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h007, 0,13'h00, 0,0,32'h0,        1,8'hDD, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h004, 0,13'h00, 0,0,32'h0,        1,8'hAA, 0,32'h0,        0,22'h2));
        // OBJ miss alone, ack and data_rdy in the same cycle
        tab.push_back(mk(0,0, 1,15'h004, 1,13'h10, 0,0,32'h0,        1,8'hAA, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h004, 1,13'h10, 1,1,32'h12345678, 1,8'hAA, 0,32'h0,        1,22'h4020));
        tab.push_back(mk(0,0, 1,15'h004, 1,13'h10, 0,0,32'h0,        1,8'hAA, 1,32'h12345678, 0,22'h4020));
        // main address moves to another line while its fetch is in WAIT
        tab.push_back(mk(0,0, 1,15'h100, 1,13'h10, 0,0,32'h0,        0,8'hAA, 1,32'h12345678, 0,22'h4020));
        tab.push_back(mk(0,0, 1,15'h100, 1,13'h10, 1,0,32'h0,        0,8'hAA, 1,32'h12345678, 1,22'h80));
        tab.push_back(mk(0,0, 1,15'h200, 1,13'h10, 0,0,32'h0,        0,8'hAA, 1,32'h12345678, 0,22'h80));
        tab.push_back(mk(0,0, 1,15'h200, 1,13'h10, 0,1,32'h11223344, 0,8'hAA, 1,32'h12345678, 0,22'h80));
        tab.push_back(mk(0,0, 1,15'h200, 1,13'h10, 0,0,32'h0,        0,8'h44, 1,32'h12345678, 0,22'h80));
        tab.push_back(mk(0,0, 1,15'h200, 1,13'h10, 1,1,32'h55667788, 0,8'h44, 1,32'h12345678, 1,22'h100));
        tab.push_back(mk(0,0, 1,15'h200, 1,13'h10, 0,0,32'h0,        1,8'h88, 1,32'h12345678, 0,22'h100));
        // simultaneous misses, OBJ changes line every time: OBJ, OBJ, then main
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h20, 0,0,32'h0,        0,8'h88, 0,32'h12345678, 0,22'h100));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h20, 1,1,32'hA0A0A0A0, 0,8'h88, 0,32'h12345678, 1,22'h4040));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h21, 0,0,32'h0,        0,8'h88, 0,32'hA0A0A0A0, 0,22'h4040));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h21, 1,1,32'hB1B1B1B1, 0,8'h88, 0,32'hA0A0A0A0, 1,22'h4042));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 0,0,32'h0,        0,8'h88, 0,32'hB1B1B1B1, 0,22'h4042));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 1,1,32'hC2C2C2C2, 0,8'h88, 0,32'hB1B1B1B1, 1,22'h180));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 0,0,32'h0,        1,8'hC2, 0,32'hB1B1B1B1, 0,22'h180));
        // downloading asserted while in REQ
        tab.push_back(mk(0,1, 1,15'h300, 1,13'h22, 0,0,32'h0,        1,8'hC2, 0,32'hB1B1B1B1, 1,22'h4044));
        tab.push_back(mk(0,1, 1,15'h300, 1,13'h22, 0,0,32'h0,        0,8'hC2, 0,32'hB1B1B1B1, 0,22'h4044));
        tab.push_back(mk(0,1, 1,15'h300, 1,13'h22, 0,0,32'h0,        0,8'hC2, 0,32'hB1B1B1B1, 0,22'h4044));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 0,0,32'h0,        0,8'hC2, 0,32'hB1B1B1B1, 0,22'h4044));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 1,1,32'hD3D3D3D3, 0,8'hC2, 0,32'hB1B1B1B1, 1,22'h4044));
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 0,0,32'h0,        0,8'hC2, 1,32'hD3D3D3D3, 0,22'h4044));
        // main fetch reaches WAIT, then reset, then a late data_rdy
        tab.push_back(mk(0,0, 1,15'h300, 1,13'h22, 1,0,32'h0,        0,8'hC2, 1,32'hD3D3D3D3, 1,22'h180));
        tab.push_back(mk(1,0, 1,15'h300, 1,13'h22, 0,0,32'h0,        0,8'hC2, 1,32'hD3D3D3D3, 0,22'h180));
        tab.push_back(mk(0,0, 0,15'h300, 0,13'h22, 0,1,32'hEEEEEEEE, 0,8'h00, 0,32'h0,        0,22'h0));
        tab.push_back(mk(0,0, 0,15'h300, 0,13'h22, 0,0,32'h0,        0,8'h00, 0,32'h0,        0,22'h0));
        // cs 1->0->1 on the same address
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        0,8'h00, 0,32'h0,        0,22'h0));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 1,1,32'hDDCCBBAA, 0,8'h00, 0,32'h0,        1,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        1,8'hBB, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 0,15'h005, 0,13'h00, 0,0,32'h0,        0,8'hBB, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        cache_mok,8'hBB, 0,32'h0, 0,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 1,1,32'hDDCCBBAA, cache_mok,8'hBB, 0,32'h0, nc_req,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        1,8'hBB, 0,32'h0,        0,22'h2));
        tab.push_back(mk(0,0, 1,15'h005, 0,13'h00, 0,0,32'h0,        1,8'hBB, 0,32'h0,        0,22'h2));

        // preamble: hold reset for a couple of edges
        rst = 1'b1; downloading = 1'b0; main_cs = 1'b0; main_addr = '0;
        obj_cs = 1'b0; obj_addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0;
        data_read = '0;
        repeat (2) @(posedge clk_rom);

        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk_rom);
            drive(tab[i]);
            #1;
            chk("main_ok",    i, {31'd0, main_ok},    {31'd0, tab[i].e_mok});
            chk("main_data",  i, {24'd0, main_data},  {24'd0, tab[i].e_mdat});
            chk("obj_ok",     i, {31'd0, obj_ok},     {31'd0, tab[i].e_ook});
            chk("obj_data",   i, obj_data,            tab[i].e_odat);
            chk("sdram_req",  i, {31'd0, sdram_req},  {31'd0, tab[i].e_req});
            chk("sdram_addr", i, {10'd0, sdram_addr}, {10'd0, tab[i].e_addr});
            $display("step %0d: rst=%0b dl=%0b main %0b/%h ok=%0b d=%h obj %0b/%h ok=%0b d=%h req=%0b addr=%h",
                     i, rst, downloading, main_cs, main_addr, main_ok, main_data,
                     obj_cs, obj_addr, obj_ok, obj_data, sdram_req, sdram_addr);
        end

        // stretched handshake: top-of-map main line, ack after 2 cycles,
        // data 3 cycles after ack, ok exactly one cycle after data_rdy
        @(negedge clk_rom);
        main_addr = 15'h7FFF; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        #1;
        chk("hs_miss_ok", 100, {31'd0, main_ok}, 32'd0);
        n = 0;
        do begin
            @(negedge clk_rom); #1; n++;
        end while (!sdram_req && n < 8);
        chk("hs_req_seen", 101, {31'd0, sdram_req}, 32'd1);
        chk("hs_req_lat",  102, n, 1);
        chk("hs_addr",     103, {10'd0, sdram_addr}, {10'd0, 22'h3FFE});
        @(negedge clk_rom); #1;
        chk("hs_req_held", 104, {31'd0, sdram_req}, 32'd1);
        sdram_ack = 1'b1;
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        #1;
        chk("hs_req_drop", 105, {31'd0, sdram_req}, 32'd0);
        repeat (2) @(negedge clk_rom);
        data_rdy = 1'b1; data_read = 32'h8899AABB;
        #1;
        chk("hs_ok_before", 106, {31'd0, main_ok}, 32'd0);
        @(negedge clk_rom);
        data_rdy = 1'b0; data_read = '0;
        #1;
        chk("hs_ok_after",   107, {31'd0, main_ok}, 32'd1);
        chk("hs_data_after", 108, {24'd0, main_data}, 32'h88);
        $display("handshake: req latency=%0d ok=%0b data=%h", n, main_ok, main_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
